// File: rtl/isa_pkg.sv
// Instruction-set definitions shared by the instruction decoder and the instruction buffer bench:
// opcode values, instruction field positions and the decoder FSM state encoding.
package isa_pkg;

   localparam int OP_W     = 4;
   localparam int OP_LSB   = 60;
   localparam int ADDR_LSB = 44;
   localparam int LEN_LSB  = 32;
   localparam int IMM_W    = 32;

   localparam logic [OP_W-1:0] OP_NOP    = 4'd0;
   localparam logic [OP_W-1:0] OP_LOAD_W = 4'd1;
   localparam logic [OP_W-1:0] OP_LOAD_A = 4'd2;
   localparam logic [OP_W-1:0] OP_MATMUL = 4'd3;
   localparam logic [OP_W-1:0] OP_STORE  = 4'd4;
   localparam logic [OP_W-1:0] OP_HALT   = 4'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HALTED
   } state_e;

   // Opcodes that produce a command for a datapath unit.
   function automatic logic is_dispatch(input logic [OP_W-1:0] op);
      return (op >= OP_LOAD_W) && (op <= OP_STORE);
   endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Decodes instructions and dispatches one command at a time to the systolic-array units.
// Latency: accept at edge N -> cmd_valid in cycle N+1; a len==0 command frees the decoder 2 cycles after accept.
// Backpressure: instr_ready only in IDLE; cmd_* held stable until cmd_ready; unit_done (or watchdog) retires.
module instruction_decoder
   import isa_pkg::*;
#(
   parameter int INSTR_W = 64,
   parameter int ADDR_W  = 16,
   parameter int LEN_W   = 12,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic [2:0]         cmd_op,
   output logic [ADDR_W-1:0]  cmd_addr,
   output logic [LEN_W-1:0]   cmd_len,
   output logic [IMM_W-1:0]   cmd_data,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   input  logic               unit_done,
   input  logic               resume,
   output logic               busy,
   output logic               halted,
   output logic               illegal_op,
   output logic               timeout_err,
   output logic [CNT_W-1:0]   retired_cnt
);

   localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [IMM_W-1:0]    imm_q, imm_d;
   logic [WD_W-1:0]     wdog_q, wdog_d;
   logic [CNT_W-1:0]    retired_cnt_q, retired_cnt_d;
   logic                illegal_q, illegal_d;
   logic                timeout_q, timeout_d;

   logic [OP_W-1:0]     in_op;
   logic                accept;

   assign in_op  = instr_in[INSTR_W-1 -: OP_W];
   assign accept = instr_valid && instr_ready;

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      len_d         = len_q;
      imm_d         = imm_q;
      wdog_d        = wdog_q;
      retired_cnt_d = retired_cnt_q;
      illegal_d     = illegal_q;
      timeout_d     = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d   = in_op[2:0];
               addr_d = instr_in[ADDR_LSB +: ADDR_W];
               len_d  = instr_in[LEN_LSB +: LEN_W];
               imm_d  = instr_in[IMM_W-1:0];
               // Decode uses all four opcode bits so 13 (low bits 5) is not mistaken for HALT.
               if (in_op == OP_NOP) begin
                  retired_cnt_d = retired_cnt_q + CNT_W'(1);
               end else if (in_op == OP_HALT) begin
                  retired_cnt_d = retired_cnt_q + CNT_W'(1);
                  state_d       = ST_HALTED;
               end else if (is_dispatch(in_op)) begin
                  state_d = ST_ISSUE;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               if (len_q == '0) begin
                  retired_cnt_d = retired_cnt_q + CNT_W'(1);
                  state_d       = ST_IDLE;
               end else begin
                  wdog_d  = '0;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // A done arriving on the watchdog's last cycle still retires cleanly.
            if (unit_done) begin
               retired_cnt_d = retired_cnt_q + CNT_W'(1);
               state_d       = ST_IDLE;
            end else if (wdog_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         ST_HALTED: begin
            if (resume) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         imm_q         <= '0;
         wdog_q        <= '0;
         retired_cnt_q <= '0;
         illegal_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         imm_q         <= imm_d;
         wdog_q        <= wdog_d;
         retired_cnt_q <= retired_cnt_d;
         illegal_q     <= illegal_d;
         timeout_q     <= timeout_d;
      end
   end

   // instr_ready is held low while rst is asserted so nothing transfers during reset.
   assign instr_ready = (state_q == ST_IDLE) && !rst;
   assign cmd_valid   = (state_q == ST_ISSUE);
   assign cmd_op      = op_q;
   assign cmd_addr    = addr_q;
   assign cmd_len     = len_q;
   assign cmd_data    = imm_q;
   assign busy        = (state_q != ST_IDLE);
   assign halted      = (state_q == ST_HALTED);
   assign illegal_op  = illegal_q;
   assign timeout_err = timeout_q;
   assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: a table of single-instruction transactions
// plus hand-written sequences for timing, back-to-back, halt, watchdog and reset cases.
module tb_instruction_decoder;

   localparam int TO = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] instr_in = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_addr;
   logic [11:0] cmd_len;
   logic [31:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic        unit_done = 1'b0;
   logic        resume = 1'b0;
   logic        busy;
   logic        halted;
   logic        illegal_op;
   logic        timeout_err;
   logic [31:0] retired_cnt;

   instruction_decoder #(
      .INSTR_W (64),
      .ADDR_W  (16),
      .LEN_W   (12),
      .TIMEOUT (TO),
      .CNT_W   (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_in    (instr_in),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .unit_done   (unit_done),
      .resume      (resume),
      .busy        (busy),
      .halted      (halted),
      .illegal_op  (illegal_op),
      .timeout_err (timeout_err),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] instr;
      int          rdy_dly;
      int          done_dly;
      logic        exp_cmd;
      logic [2:0]  exp_op;
      logic [15:0] exp_addr;
      logic [11:0] exp_len;
      logic [31:0] exp_data;
      logic        exp_retire;
      logic        exp_illegal;
   } vec_t;

   vec_t        tbl [10];
   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] exp_ret = 0;
   logic        exp_ill = 1'b0;
   int          acc_cnt = 0;
   int          cmd_cnt = 0;

   always @(posedge clk) begin
      if (instr_valid && instr_ready) acc_cnt++;
      if (cmd_valid) cmd_cnt++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      chk($sformatf("v%0d_ready_in", idx), instr_ready, 1);
      instr_in    = v.instr;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      if (v.exp_cmd) begin
         chk($sformatf("v%0d_cmd_valid", idx), cmd_valid, 1);
         chk($sformatf("v%0d_cmd_op", idx), cmd_op, v.exp_op);
         chk($sformatf("v%0d_cmd_addr", idx), cmd_addr, v.exp_addr);
         chk($sformatf("v%0d_cmd_len", idx), cmd_len, v.exp_len);
         chk($sformatf("v%0d_cmd_data", idx), cmd_data, v.exp_data);
         chk($sformatf("v%0d_ready_issue", idx), instr_ready, 0);
         // unit_done pulses while the command is still in ISSUE must be ignored
         for (int k = 0; k < v.rdy_dly; k++) begin
            unit_done = 1'b1;
            @(negedge clk);
            unit_done = 1'b0;
            chk($sformatf("v%0d_hold_valid", idx), cmd_valid, 1);
            chk($sformatf("v%0d_hold_addr", idx), cmd_addr, v.exp_addr);
         end
         cmd_ready = 1'b1;
         @(negedge clk);
         cmd_ready = 1'b0;
         if (v.exp_len != 0) begin
            chk($sformatf("v%0d_wait_busy", idx), busy, 1);
            chk($sformatf("v%0d_wait_valid", idx), cmd_valid, 0);
            repeat (v.done_dly) @(negedge clk);
            unit_done = 1'b1;
            @(negedge clk);
            unit_done = 1'b0;
         end
      end else begin
         chk($sformatf("v%0d_no_cmd", idx), cmd_valid, 0);
      end
      if (v.exp_retire) exp_ret++;
      exp_ill = exp_ill | v.exp_illegal;
      chk($sformatf("v%0d_busy", idx), busy, 0);
      chk($sformatf("v%0d_ready_out", idx), instr_ready, 1);
      chk($sformatf("v%0d_retired", idx), retired_cnt, exp_ret);
      chk($sformatf("v%0d_illegal", idx), illegal_op, exp_ill);
      chk($sformatf("v%0d_halted", idx), halted, 0);
   endtask

   // Dispatch a command, accept it, and leave the decoder in the first WAIT cycle.
   task automatic enter_wait(input logic [63:0] ins);
      @(negedge clk);
      instr_in    = ins;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      cmd_ready   = 1'b1;
      @(negedge clk);
      cmd_ready   = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int a0, c0;
      tbl[0] = '{64'h0_ABCD_123_55AA55AA, 0, 0, 1'b0, 3'd0, 16'h0000, 12'h000, 32'h00000000, 1'b1, 1'b0};
      tbl[1] = '{64'h1_1234_010_CAFEF00D, 0, 2, 1'b1, 3'd1, 16'h1234, 12'h010, 32'hCAFEF00D, 1'b1, 1'b0};
      tbl[2] = '{64'h2_FFFF_FFF_FFFFFFFF, 2, 0, 1'b1, 3'd2, 16'hFFFF, 12'hFFF, 32'hFFFFFFFF, 1'b1, 1'b0};
      tbl[3] = '{64'h3_0100_000_00000003, 1, 0, 1'b1, 3'd3, 16'h0100, 12'h000, 32'h00000003, 1'b1, 1'b0};
      tbl[4] = '{64'h4_0000_001_00000001, 0, 5, 1'b1, 3'd4, 16'h0000, 12'h001, 32'h00000001, 1'b1, 1'b0};
      tbl[5] = '{64'hF_0000_004_00000000, 0, 0, 1'b0, 3'd0, 16'h0000, 12'h000, 32'h00000000, 1'b0, 1'b1};
      tbl[6] = '{64'h1_8000_800_80000001, 3, 1, 1'b1, 3'd1, 16'h8000, 12'h800, 32'h80000001, 1'b1, 1'b0};
      tbl[7] = '{64'h6_1111_111_11111111, 0, 0, 1'b0, 3'd0, 16'h0000, 12'h000, 32'h00000000, 1'b0, 1'b1};
      tbl[8] = '{64'hD_2222_000_00000000, 0, 0, 1'b0, 3'd0, 16'h0000, 12'h000, 32'h00000000, 1'b0, 1'b1};
      tbl[9] = '{64'h9_3333_000_00000000, 0, 0, 1'b0, 3'd0, 16'h0000, 12'h000, 32'h00000000, 1'b0, 1'b1};

      // Reset state
      #12;
      chk("rst_ready", instr_ready, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal_op, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_retired", retired_cnt, 0);
      chk("rst_cmd_fields", {cmd_op, cmd_addr, cmd_len, cmd_data}, 0);
      @(negedge clk);
      rst = 1'b0;

      // MATMUL timing: accept at N, cmd_ready sampled at N+3, unit_done at N+7
      @(negedge clk);
      chk("t1_ready_n", instr_ready, 1);
      instr_in    = 64'h3_0040_008_DEADBEEF;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("t1_valid_n1", cmd_valid, 1);
      chk("t1_op", cmd_op, 3);
      chk("t1_addr", cmd_addr, 16'h0040);
      chk("t1_len", cmd_len, 8);
      chk("t1_ready_n1", instr_ready, 0);
      @(negedge clk);
      chk("t1_valid_n2", cmd_valid, 1);
      @(negedge clk);
      chk("t1_valid_n3", cmd_valid, 1);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      chk("t1_valid_n4", cmd_valid, 0);
      chk("t1_busy_n4", busy, 1);
      repeat (3) @(negedge clk);
      chk("t1_ready_n7", instr_ready, 0);
      unit_done = 1'b1;
      @(negedge clk);
      unit_done = 1'b0;
      chk("t1_ready_n8", instr_ready, 1);
      exp_ret = 1;
      chk("t1_retired", retired_cnt, exp_ret);

      // Back-to-back NOPs with instr_valid held
      @(negedge clk);
      a0 = acc_cnt;
      c0 = cmd_cnt;
      instr_in    = 64'h0_0000_000_00000000;
      instr_valid = 1'b1;
      repeat (4) @(negedge clk);
      instr_valid = 1'b0;
      exp_ret += 4;
      chk("t2_accepts", acc_cnt - a0, 4);
      chk("t2_retired", retired_cnt, exp_ret);
      chk("t2_no_cmd", cmd_cnt - c0, 0);

      for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

      // HALT followed by a waiting LOAD_W
      @(negedge clk);
      instr_in    = 64'h5_0000_000_00000000;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_in = 64'h1_00AA_000_00000007;
      exp_ret++;
      chk("t4_halted", halted, 1);
      chk("t4_ready", instr_ready, 0);
      chk("t4_retired", retired_cnt, exp_ret);
      a0 = acc_cnt;
      repeat (3) @(negedge clk);
      chk("t4_still_halted", halted, 1);
      chk("t4_no_accept", acc_cnt - a0, 0);
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      chk("t4_resumed", halted, 0);
      chk("t4_ready_after", instr_ready, 1);
      @(negedge clk);
      instr_valid = 1'b0;
      chk("t4_cmd_valid", cmd_valid, 1);
      chk("t4_cmd_op", cmd_op, 1);
      chk("t4_cmd_addr", cmd_addr, 16'h00AA);
      chk("t4_cmd_data", cmd_data, 7);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      exp_ret++;
      chk("t4_retired2", retired_cnt, exp_ret);
      chk("t4_idle", busy, 0);

      // unit_done on the watchdog's final cycle retires without error
      enter_wait(64'h2_0010_002_00000000);
      repeat (TO - 1) @(negedge clk);
      chk("dl_busy_last", busy, 1);
      chk("dl_no_err_yet", timeout_err, 0);
      unit_done = 1'b1;
      @(negedge clk);
      unit_done = 1'b0;
      exp_ret++;
      chk("dl_no_err", timeout_err, 0);
      chk("dl_idle", busy, 0);
      chk("dl_retired", retired_cnt, exp_ret);

      // STORE with unit_done withheld -> watchdog
      enter_wait(64'h4_0020_004_00000000);
      repeat (TO - 1) @(negedge clk);
      chk("t5_busy_last", busy, 1);
      chk("t5_err_not_yet", timeout_err, 0);
      @(negedge clk);
      chk("t5_timeout", timeout_err, 1);
      chk("t5_idle", busy, 0);
      chk("t5_ready", instr_ready, 1);
      chk("t5_retired", retired_cnt, exp_ret);

      // Asynchronous reset mid-WAIT
      enter_wait(64'h2_0300_005_00000000);
      chk("t6_busy_pre", busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_cmd_valid", cmd_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_illegal", illegal_op, 0);
      chk("t6_timeout", timeout_err, 0);
      chk("t6_halted", halted, 0);
      chk("t6_retired", retired_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset while a command is presented
      @(negedge clk);
      instr_in    = 64'h3_0055_003_00000000;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("t6b_valid_pre", cmd_valid, 1);
      #1 rst = 1'b1;
      #1;
      chk("t6b_valid", cmd_valid, 0);
      chk("t6b_addr", cmd_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_ret = 0;
      exp_ill = 1'b0;
      run_vec(tbl[0], 100);
      run_vec(tbl[3], 103);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
